// File: rtl/bsm_operand_serializer.sv
// Operand serializer feeding the bit-serial multiplier.
// Accepts a signed (A, B) pair with per-operand widths over valid/ready,
// pulses mul_start, then shifts both operands out LSB-first, sign-extended
// to the larger width. It then waits for mul_done, or gives up after a timeout.
// Optional macro BSM_SER_SKID_EN adds a one-entry holding buffer so a new
// pair can be accepted while an operation is in flight.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | ready for a new pair (in_ready = 1)
// START     | one-cycle mul_start pulse; operands captured
// SHIFT     | one operand bit pair per cycle, maxW cycles
// WAIT_DONE | bits held 0; waiting for mul_done or timeout
module bsm_operand_serializer #(
   parameter int DW           = 16,
   parameter int DONE_TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_a,
   input  logic [DW-1:0] in_b,
   input  logic [4:0]    in_wa,
   input  logic [4:0]    in_wb,
   output logic          mul_start,
   output logic          mul_bita,
   output logic          mul_bitb,
   output logic [4:0]    mul_wa,
   output logic [4:0]    mul_wb,
   input  logic          mul_done,
   output logic          busy,
   output logic          err
);

   typedef enum logic [1:0] {IDLE, START, SHIFT, WAIT_DONE} state_t;

   localparam int          TW     = $clog2(DONE_TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(DONE_TIMEOUT - 1);
   localparam logic [4:0]  DW5    = 5'(DW);

   state_t        state;
   logic [DW-1:0] a_r, b_r;
   logic [4:0]    maxw_r;
   logic [4:0]    k_r;
   logic [TW-1:0] tcnt;

   logic          accept, in_bad, accept_ok, leave, go_start, sk_full;
   logic [DW-1:0] src_a, src_b;
   logic [4:0]    src_wa, src_wb, src_maxw;

   // Bit k of a w-bit two's complement value, sign-extended beyond w.
   function automatic logic sel_bit(logic [DW-1:0] v, logic [4:0] w, logic [4:0] k);
      logic [4:0]    idx;
      logic [DW-1:0] sh;
      idx = (k < w) ? k : (w - 5'd1);
      sh  = v >> idx;
      return sh[0];
   endfunction

`ifdef BSM_SER_SKID_EN
   logic [DW-1:0] sk_a, sk_b;
   logic [4:0]    sk_wa, sk_wb;
   logic          store;

   assign in_ready = ~sk_full;
   assign store    = accept_ok & (state != IDLE) & ~leave;

   // Holding buffer: filled by a legal pair arriving mid-operation, freed when
   // it is loaded into the working registers on the way out of WAIT_DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sk_full <= 1'b0;
         sk_a    <= '0;
         sk_b    <= '0;
         sk_wa   <= '0;
         sk_wb   <= '0;
      end else if (go_start && sk_full) begin
         sk_full <= 1'b0;
      end else if (store) begin
         sk_full <= 1'b1;
         sk_a    <= in_a;
         sk_b    <= in_b;
         sk_wa   <= in_wa;
         sk_wb   <= in_wb;
      end
   end
`else
   assign in_ready = (state == IDLE);
   assign sk_full  = 1'b0;
`endif

   assign busy      = (state != IDLE);
   assign accept    = in_valid & in_ready;
   assign in_bad    = (in_wa == 5'd0) | (in_wa > DW5) | (in_wb == 5'd0) | (in_wb > DW5);
   assign accept_ok = accept & ~in_bad;
   assign leave     = (state == WAIT_DONE) & (mul_done | (tcnt == T_LAST));
   assign go_start  = ((state == IDLE) & accept_ok) | (leave & (sk_full | accept_ok));

   // Source of the next operation: the holding buffer if occupied, else the inputs.
   always_comb begin
      src_a  = in_a;
      src_b  = in_b;
      src_wa = in_wa;
      src_wb = in_wb;
`ifdef BSM_SER_SKID_EN
      if (sk_full) begin
         src_a  = sk_a;
         src_b  = sk_b;
         src_wa = sk_wa;
         src_wb = sk_wb;
      end
`endif
      src_maxw = (src_wa > src_wb) ? src_wa : src_wb;
   end

   // Sequencer FSM with registered start, serial bits, widths and error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         maxw_r    <= '0;
         k_r       <= '0;
         tcnt      <= '0;
         mul_start <= 1'b0;
         mul_bita  <= 1'b0;
         mul_bitb  <= 1'b0;
         mul_wa    <= '0;
         mul_wb    <= '0;
         err       <= 1'b0;
      end else begin
         mul_start <= 1'b0;
         err       <= accept & in_bad;
         case (state)
            IDLE: ;
            START: begin
               mul_bita <= sel_bit(a_r, mul_wa, 5'd0);
               mul_bitb <= sel_bit(b_r, mul_wb, 5'd0);
               k_r      <= 5'd1;
               state    <= SHIFT;
            end
            SHIFT: begin
               if (k_r == maxw_r) begin
                  mul_bita <= 1'b0;
                  mul_bitb <= 1'b0;
                  tcnt     <= '0;
                  state    <= WAIT_DONE;
               end else begin
                  mul_bita <= sel_bit(a_r, mul_wa, k_r);
                  mul_bitb <= sel_bit(b_r, mul_wb, k_r);
                  k_r      <= k_r + 5'd1;
               end
            end
            WAIT_DONE: begin
               if (leave) begin
                  state <= IDLE;
                  if (!mul_done) err <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         // A new operation overrides the return to IDLE.
         if (go_start) begin
            a_r       <= src_a;
            b_r       <= src_b;
            mul_wa    <= src_wa;
            mul_wb    <= src_wb;
            maxw_r    <= src_maxw;
            k_r       <= 5'd0;
            state     <= START;
            mul_start <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bsm_operand_serializer.sv
// Self-checking bench for bsm_operand_serializer: the driver pushes expected
// streams/products on accept, and a multiplier model pops and checks them on
// mul_start, then answers with mul_done.
module tb_bsm_operand_serializer;

   localparam int DW = 16;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_a, in_b;
   logic [4:0]    in_wa, in_wb;
   logic          mul_start, mul_bita, mul_bitb;
   logic [4:0]    mul_wa, mul_wb;
   logic          mul_done = 1'b0;
   logic          busy, err;

   bsm_operand_serializer #(.DW(DW), .DONE_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_wa(in_wa), .in_wb(in_wb),
      .mul_start(mul_start), .mul_bita(mul_bita), .mul_bitb(mul_bitb),
      .mul_wa(mul_wa), .mul_wb(mul_wb), .mul_done(mul_done),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int sext(input logic [31:0] v, input int w);
      logic [31:0] s;
      s = v << (32 - w);
      return $signed(s) >>> (32 - w);
   endfunction

   typedef struct {
      int          wa, wb, maxw;
      logic [31:0] sa_bits, sb_bits;
      int          prod;
      int          exp_start;
   } item_t;

   item_t sb[$];

   // ---------------- multiplier model / monitor ----------------
   int          ph = 0;
   item_t       cur;
   int          kk;
   logic [31:0] ga, gb;
   int          dup, moved;
   logic        done_block = 1'b0;

   task automatic take_start();
      if (sb.size() == 0) begin
         chk("start_unexp", 1, 0);
      end else begin
         cur = sb.pop_front();
         chk("start_cyc", cyc, cur.exp_start);
         chk("mul_wa", int'(mul_wa), cur.wa);
         chk("mul_wb", int'(mul_wb), cur.wb);
         kk = 0; ga = '0; gb = '0; dup = 0; moved = 0;
         ph = 1;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            ph = 0;
            mul_done = 1'b0;
         end else begin
            case (ph)
               0: if (mul_start) take_start();
               1: begin
                  if (mul_start) dup = 1;
                  if (int'(mul_wa) != cur.wa || int'(mul_wb) != cur.wb) moved = 1;
                  ga[kk] = mul_bita;
                  gb[kk] = mul_bitb;
                  kk++;
                  if (kk == cur.maxw) begin
                     chk("bita_stream", int'(ga), int'(cur.sa_bits));
                     chk("bitb_stream", int'(gb), int'(cur.sb_bits));
                     chk("product", sext(ga, cur.maxw) * sext(gb, cur.maxw), cur.prod);
                     chk("start_dup", dup, 0);
                     chk("w_hold", moved, 0);
                     ph = done_block ? 0 : 2;
                  end
               end
               2: begin
                  chk("wait_bits", int'({mul_bita, mul_bitb}), 0);
                  chk("wait_busy", int'(busy), 1);
                  mul_done = 1'b1;
                  ph = 3;
               end
               default: begin
                  mul_done = 1'b0;
                  chk("post_done_busy", int'(busy), int'(mul_start));
                  ph = 0;
                  if (mul_start) take_start();
               end
            endcase
         end
      end
   end

   // ---------------- driver ----------------
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [4:0] wa,
                       input logic [4:0] wb, input int exp_start, output int acc);
      item_t it;
      int    sa, sbv, mask;
      in_a = a; in_b = b; in_wa = wa; in_wb = wb; in_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 200; i++) begin
         if (in_ready) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      if (wa >= 5'd1 && wa <= 5'd16 && wb >= 5'd1 && wb <= 5'd16) begin
         sa  = sext({16'd0, a}, int'(wa));
         sbv = sext({16'd0, b}, int'(wb));
         it.wa   = int'(wa);
         it.wb   = int'(wb);
         it.maxw = (wa > wb) ? int'(wa) : int'(wb);
         mask    = (1 << it.maxw) - 1;
         it.sa_bits   = 32'(sa & mask);
         it.sb_bits   = 32'(sbv & mask);
         it.prod      = sa * sbv;
         it.exp_start = (exp_start < 0) ? acc + 1 : exp_start;
         sb.push_back(it);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         if (!busy && ph == 0 && !mul_done) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      int acc, acc2, errc;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_wa = '0; in_wb = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_start", int'(mul_start), 0);
      chk("rst_wa", int'(mul_wa), 0);
      chk("rst_wb", int'(mul_wb), 0);
      rst = 1'b0;
      @(negedge clk);

      // A=-3 (4b), B=5 (4b): product -15, IDLE three cycles after the last bit
      send(16'hFFFD, 16'h0005, 5'd4, 5'd4, -1, acc);
      wait_idle();
      chk("idle_latency", cyc - acc, 7);

      // A=-3 (3b, upper bits garbage), B=7 (6b): maxW 6, product -21
      send(16'hA5FD, 16'h0007, 5'd3, 5'd6, -1, acc);
      wait_idle();

      // width boundaries
      send(16'h0001, 16'h8000, 5'd1, 5'd16, -1, acc);
      wait_idle();
      send(16'h7FFF, 16'h0000, 5'd16, 5'd1, -1, acc);
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         send(16'($urandom), 16'($urandom), 5'($urandom_range(1, 16)),
              5'($urandom_range(1, 16)), -1, acc);
         wait_idle();
      end

      // illegal widths: one-cycle err, no start, stays ready
      send(16'h0003, 16'h0003, 5'd0, 5'd4, -1, acc);
      chk("err_wa0", int'(err), 1);
      chk("err_wa0_ready", int'(in_ready), 1);
      @(negedge clk);
      chk("err_wa0_clear", int'(err), 0);
      send(16'h0003, 16'h0003, 5'd4, 5'd17, -1, acc);
      chk("err_wb17", int'(err), 1);
      chk("err_wb17_busy", int'(busy), 0);
      @(negedge clk);
      chk("err_wb17_clear", int'(err), 0);
      chk("err_wb17_ready", int'(in_ready), 1);

      // timeout with mul_done held low
      done_block = 1'b1;
      send(16'h0002, 16'h0003, 5'd4, 5'd4, -1, acc);
      errc = -1;
      for (int i = 0; i < 300; i++) begin
         if (err) begin
            errc = cyc;
            break;
         end
         @(negedge clk);
      end
      chk("timeout_cyc", errc - acc, 2 + 4 + TO);
      @(negedge clk);
      chk("timeout_err_clear", int'(err), 0);
      chk("timeout_idle", int'(busy), 0);
      chk("timeout_ready", int'(in_ready), 1);
      done_block = 1'b0;

      // async reset during SHIFT at k=2
      send(16'hFFFF, 16'h00FF, 5'd8, 5'd8, -1, acc);
      for (int i = 0; i < 20 && cyc < acc + 4; i++) @(negedge clk);
      chk("pre_rst_bita", int'(mul_bita), 1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_bita", int'(mul_bita), 0);
      chk("rst_mid_bitb", int'(mul_bitb), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_ready", int'(in_ready), 1);
      chk("rst_mid_wa", int'(mul_wa), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(16'hFFFB, 16'h0003, 5'd4, 5'd3, -1, acc);
      wait_idle();

      // second pair offered while the first is shifting
      send(16'h0005, 16'h0006, 5'd4, 5'd4, -1, acc);
      @(negedge clk);
`ifdef BSM_SER_SKID_EN
      send(16'hFFFE, 16'h0003, 5'd4, 5'd3, acc + 7, acc2);
      chk("skid_accept", acc2 - acc, 2);
      chk("skid_ready_drop", int'(in_ready), 0);
`else
      chk("busy_not_ready", int'(in_ready), 0);
      send(16'hFFFE, 16'h0003, 5'd4, 5'd3, -1, acc2);
      chk("wait_accept", acc2 - acc, 7);
`endif
      wait_idle();

      chk("sb_left", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/bsm_operand_serializer.md
Name: bsm_operand_serializer

Overview:
- Upstream feeder for the bit-serial multiplier.
- Accepts one parallel signed operand pair (A, B), each with its own width, over a valid/ready handshake.
- Issues the multiplier's one-cycle start pulse, then shifts both operands out LSB-first with sign extension to the larger width.
- Holds WA/WB stable for the whole operation and waits for the multiplier's done before accepting the next pair, with a timeout guard.

Parameters:
- DW, 16, maximum operand width; legal WA/WB range is 1..DW. DW ≤ 16 so the product fits in 32 bits.
- DONE_TIMEOUT, 64, maximum cycles spent in WAIT_DONE before abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- in_a  in  DW  operand A, two's complement, right-aligned in the low in_wa bits
- in_b  in  DW  operand B, two's complement, right-aligned in the low in_wb bits
- in_wa  in  5  width of A
- in_wb  in  5  width of B
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_bita  out  1  serial A bit, registered
- mul_bitb  out  1  serial B bit, registered
- mul_wa  out  5  width A to the multiplier, registered
- mul_wb  out  5  width B to the multiplier, registered
- mul_done  in  1  multiplier done
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on an illegal width or a timeout

Behaviour:
- Reset values (asynchronous): state = IDLE; in_ready = 1; mul_start, mul_bita, mul_bitb, busy and err = 0; mul_wa, mul_wb = 0; all internal counters and registers = 0.
- Accept condition: in_valid & in_ready at the rising edge of cycle t.
- Illegal widths: if in_wa or in_wb is 0 or greater than DW:
  - The pair is consumed.
  - err = 1 in cycle t+1.
  - No start is issued; state stays IDLE.
- Legal widths: at accept, capture A, B, WA and WB into internal registers; drive mul_wa/mul_wb from the captured values; set maxW = max(WA, WB).
- Widths stay constant: mul_wa/mul_wb change only at an accept and hold until the next accept.
- States:
  - IDLE: in_ready = 1. On a legal accept, go to START.
  - START (cycle t+1): mul_start = 1, bits = 0, in_ready = 0. Go to SHIFT with k = 0.
  - SHIFT (cycles t+2 .. t+1+maxW):
    - mul_bita = A[k] when k < WA, else A[WA-1] (sign extension).
    - mul_bitb = B[k] when k < WB, else B[WB-1].
    - k increments each cycle. After k = maxW-1, go to WAIT_DONE.
  - WAIT_DONE:
    - Bits driven 0.
    - A timeout counter counts from 0. On mul_done = 1, go to IDLE next cycle.
    - If the counter reaches DONE_TIMEOUT-1 with no mul_done: pulse err and go to IDLE.
- mul_done is expected in cycle t+2+maxW. mul_done arriving in any state other than WAIT_DONE is ignored.
- mul_start is never asserted in two consecutive cycles.
- busy = (state != IDLE).
- Widths up to 16 only: the k counter is 5 bits and never wraps.
- Asynchronous reset in any state aborts the operation:
  - Outputs go to their reset values immediately.
  - The pair in flight is discarded.
  - No start is reissued.
- in_valid is not required to be stable while in_ready = 0. Input data is sampled only on an accept.

Optional Feature:
- Macro: BSM_SER_SKID_EN.
- Defined:
  - A one-entry holding buffer is added. in_ready = 1 whenever the buffer is empty, including while busy.
  - A pair accepted while busy is stored, with width legality checked at storage time.
  - Leaving WAIT_DONE (done or timeout) with the buffer full goes directly to START next cycle. The buffer is loaded into the working registers and mul_wa/mul_wb in that cycle, and the buffer is freed.
  - An illegal pair is never buffered; err pulses as in IDLE.
- Not defined:
  - No buffer. in_ready = (state == IDLE).

Test Plan:
- A = -3 (WA=4, 4'b1101), B = 5 (WB=4), accept at cycle 0:
  - mul_start at cycle 1 only.
  - mul_bita = 1,0,1,1 and mul_bitb = 1,0,1,0 in cycles 2-5.
  - mul_done from the model at cycle 6 gives product -15; IDLE at cycle 7.
- A = -3 (WA=3, 3'b101), B = 7 (WB=6):
  - maxW = 6.
  - mul_bita = 1,0,1,1,1,1 and mul_bitb = 1,1,1,0,0,0.
  - Product -21.
  - mul_wa = 3 and mul_wb = 6 held throughout.
- in_wa = 0, then in_wb = 17:
  - Each gives err = 1 for exactly one cycle.
  - No mul_start; in_ready stays 1.
- mul_done tied 0:
  - Exactly DONE_TIMEOUT cycles after entering WAIT_DONE, err pulses; then IDLE, in_ready = 1.
- rst asserted during SHIFT at k = 2:
  - Outputs drop to reset values immediately.
  - After release, a new pair runs normally with a single start.
- With BSM_SER_SKID_EN defined:
  - Second pair offered during SHIFT is accepted; in_ready then drops.
  - Second mul_start occurs the cycle after the first mul_done is seen in WAIT_DONE.
  - Without the macro, the second pair waits until IDLE.
